// File: rtl/brent_kung_sub_pipe_if.sv
// Handshake bundle for the Brent-Kung subtractor pipeline.
// master: source/sink side, slave: the subtractor itself.
//
// Signals:
//   in_valid/in_ready    input-side handshake
//   minuend   [WIDTH:0]  S, adder-style sum with carry-out on top
//   subtrahend[WIDTH-1:0] B
//   out_valid/out_ready  output-side handshake
//   diff, diff_hi, underflow  result of S - B
interface brent_kung_sub_pipe_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             diff_hi;
    logic             underflow;

    modport master (
        output in_valid,
        output minuend,
        output subtrahend,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  diff_hi,
        input  underflow
    );

    modport slave (
        input  in_valid,
        input  minuend,
        input  subtrahend,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output diff_hi,
        output underflow
    );
endinterface

// File: rtl/brent_kung_sub_pipe.sv
// 3-stage pipelined subtractor D = S - B built on a Brent-Kung
// parallel-prefix borrow network; undoes the team's BK adder.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    brent_kung_sub_pipe_if.slave (valid/ready in, valid/ready out,
//          minuend S, subtrahend B, diff, diff_hi, underflow)
module brent_kung_sub_pipe #(
    parameter int WIDTH = 12
) (
    input logic                  clk,
    input logic                  rst_n,
    brent_kung_sub_pipe_if.slave bus
);
    // Prefix vector: position 0 is the carry-in (g=1, p=0),
    // positions 1..WIDTH+1 are bits 0..WIDTH of S + ~{0,B}.
    localparam int M   = WIDTH + 2;
    localparam int LVL = $clog2(M);

    // Handshake
    logic w_adv1;
    logic w_adv2;
    logic w_adv3;
    logic w_in_fire;
    logic r_v1;
    logic r_v2;
    logic r_v3;

    // Stage 1 datapath
    logic [WIDTH:0] w_nb;
    logic [M-1:0]   w_g0;
    logic [M-1:0]   w_p0;
    logic [M-1:0]   r_s1_g;
    logic [M-1:0]   r_s1_p;

    // Stage 2 datapath
    logic [M-1:0]   w_ug;
    logic [M-1:0]   w_up;
    logic [M-1:0]   r_s2_g;
    logic [M-1:0]   r_s2_p;
    logic [WIDTH:0] r_s2_h;

    // Stage 3 datapath
    logic [M-1:0]     w_dg;
    logic [WIDTH:0]   w_r;
    logic             w_cout;
    logic [WIDTH-1:0] r_diff;
    logic             r_diff_hi;
    logic             r_underflow;

    // Group P of nodes that already span the carry-in is always
    // zero and is never consumed by the down-sweep.
    logic w_unused_p;
    assign w_unused_p = ^r_s2_p;

    // ---------------------------------------------------------
    // Handshake: a stage moves when empty or when its successor
    // moves; purely combinational, so a full pipe can pop and
    // push in the same cycle.
    // ---------------------------------------------------------
    assign w_adv3    = ~r_v3 | bus.out_ready;
    assign w_adv2    = ~r_v2 | w_adv3;
    assign w_adv1    = ~r_v1 | w_adv2;
    assign w_in_fire = bus.in_valid & w_adv1;

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r_v3;
    assign bus.diff      = r_diff;
    assign bus.diff_hi   = r_diff_hi;
    assign bus.underflow = r_underflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_adv1) r_v1 <= bus.in_valid;
            if (w_adv2) r_v2 <= r_v1;
            if (w_adv3) r_v3 <= r_v2;
        end
    end

    // ---------------------------------------------------------
    // ST1: bitwise generate / propagate of S + ~{0,B}.
    // ---------------------------------------------------------
    assign w_nb = ~{1'b0, bus.subtrahend};
    assign w_g0 = {bus.minuend & w_nb, 1'b1};
    assign w_p0 = {bus.minuend ^ w_nb, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_g <= '0;
            r_s1_p <= '0;
        end else if (w_in_fire) begin
            r_s1_g <= w_g0;
            r_s1_p <= w_p0;
        end
    end

    // ---------------------------------------------------------
    // ST2: Brent-Kung up-sweep. At level l, node i with
    // (i+1) a multiple of 2^(l+1) absorbs node i-2^l.
    // ---------------------------------------------------------
    always_comb begin
        w_ug = r_s1_g;
        w_up = r_s1_p;
        for (int l = 0; l < LVL; l++) begin
            for (int i = (1 << (l + 1)) - 1; i < M;
                 i += (1 << (l + 1))) begin
                w_ug[i] = w_ug[i] | (w_up[i] & w_ug[i - (1 << l)]);
                w_up[i] = w_up[i] & w_up[i - (1 << l)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_g <= '0;
            r_s2_p <= '0;
            r_s2_h <= '0;
        end else if (w_adv2 && r_v1) begin
            r_s2_g <= w_ug;
            r_s2_p <= w_up;
            r_s2_h <= r_s1_p[M-1:1];
        end
    end

    // ---------------------------------------------------------
    // ST3: Brent-Kung down-sweep. Top level first; node i whose
    // span is exactly 2^l (and not yet rooted at position 0)
    // absorbs the full prefix held at i-2^l.
    // After this w_dg[k] is the carry into result bit k.
    // ---------------------------------------------------------
    always_comb begin
        w_dg = r_s2_g;
        for (int l = LVL - 1; l >= 0; l--) begin
            for (int i = 3 * (1 << l) - 1; i < M;
                 i += (1 << (l + 1))) begin
                w_dg[i] = w_dg[i] | (r_s2_p[i] & w_dg[i - (1 << l)]);
            end
        end
    end

    assign w_r    = r_s2_h ^ w_dg[WIDTH:0];
    assign w_cout = w_dg[WIDTH+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff      <= '0;
            r_diff_hi   <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_adv3 && r_v2) begin
            r_diff      <= w_r[WIDTH-1:0];
            // No carry out of the inverted add means S < B.
            r_diff_hi   <= w_r[WIDTH] & w_cout;
            r_underflow <= ~w_cout;
        end
    end

endmodule
